// File: rtl/bank_write_arbiter.sv
// Register-bank write port shared by two writeback requesters, with a starvation-bounded
// priority arbiter and a busy-register scoreboard that drives the read-operand stall.
module bank_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_A,
    input  logic [4:0]  AW_A,
    input  logic [31:0] DATA_A,
    output logic        GNT_A,
    input  logic        REQ_B,
    input  logic [4:0]  AW_B,
    input  logic [31:0] DATA_B,
    output logic        GNT_B,
    input  logic        RSV,
    input  logic [4:0]  RSV_REG,
    input  logic [4:0]  AR1,
    input  logic [4:0]  AR2,
    output logic        STALL,
    output logic        REG_WRITE,
    output logic [4:0]  AW,
    output logic [31:0] DATAIN,
    output logic [31:0] BUSY
);

    typedef enum logic [0:0] {PriA, PriB} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic        contend;
    logic        grant;
    logic [4:0]  gnt_aw;
    logic [31:0] gnt_data;
    logic [31:0] busy_d;

    assign contend  = REQ_A && REQ_B;
    assign cnt_inc  = cnt_q + 4'd1;
    assign grant    = GNT_A || GNT_B;
    assign gnt_aw   = GNT_B ? AW_B : AW_A;
    assign gnt_data = GNT_B ? DATA_B : DATA_A;

    // Grants and arbiter next state
    always_comb begin
        GNT_A   = 1'b0;
        GNT_B   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!RST) begin
            if (contend) begin
                GNT_A = (state_q == PriA);
                GNT_B = (state_q == PriB);
            end else begin
                GNT_A = REQ_A;
                GNT_B = REQ_B;
            end
        end
        if (GNT_B) begin
            state_d = PriA;
            cnt_d   = '0;
        end else if (!REQ_B) begin
            cnt_d = '0;
        end else if (contend && GNT_A) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'(STARVE_LIMIT)) begin
                state_d = PriB;
            end
        end
    end

    // Clear runs first so a same-edge reservation of the written register wins
    always_comb begin
        busy_d = BUSY;
        if (REG_WRITE) begin
            busy_d[AW] = 1'b0;
        end
        if (RSV && (RSV_REG != 5'd0)) begin
            busy_d[RSV_REG] = 1'b1;
        end
    end

    assign STALL = ((AR1 != 5'd0) && BUSY[AR1]) || ((AR2 != 5'd0) && BUSY[AR2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= PriA;
            cnt_q     <= '0;
            REG_WRITE <= 1'b0;
            AW        <= '0;
            DATAIN    <= '0;
            BUSY      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Writes to r0 finish the handshake but never reach the bank
            REG_WRITE <= grant && (gnt_aw != 5'd0);
            if (grant) begin
                AW     <= gnt_aw;
                DATAIN <= gnt_data;
            end
            BUSY <= busy_d;
        end
    end

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Self-checking bench for bank_write_arbiter: reference model predicts grants, busy vector and
// stall; a scoreboard queue carries each cycle's expected bank-write outputs to the next cycle.
module tb_bank_write_arbiter;

    localparam int unsigned LIMIT = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_A, REQ_B, GNT_A, GNT_B;
    logic [4:0]  AW_A, AW_B;
    logic [31:0] DATA_A, DATA_B;
    logic        RSV;
    logic [4:0]  RSV_REG, AR1, AR2;
    logic        STALL, REG_WRITE;
    logic [4:0]  AW;
    logic [31:0] DATAIN, BUSY;

    always #5 CLK = ~CLK;

    bank_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_A     (REQ_A),
        .AW_A      (AW_A),
        .DATA_A    (DATA_A),
        .GNT_A     (GNT_A),
        .REQ_B     (REQ_B),
        .AW_B      (AW_B),
        .DATA_B    (DATA_B),
        .GNT_B     (GNT_B),
        .RSV       (RSV),
        .RSV_REG   (RSV_REG),
        .AR1       (AR1),
        .AR2       (AR2),
        .STALL     (STALL),
        .REG_WRITE (REG_WRITE),
        .AW        (AW),
        .DATAIN    (DATAIN),
        .BUSY      (BUSY)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  aw;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_pri_b = 1'b0;
    logic [3:0]  m_cnt = '0;
    logic [31:0] m_busy = '0;
    logic [4:0]  m_aw = '0;
    logic [31:0] m_data = '0;
    logic        cur_we = 1'b0;
    logic [4:0]  cur_aw = '0;
    logic        last_ga, last_gb;
    string       order;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; checks pre-edge outputs, then post-edge state
    task automatic step();
        logic        ga, gb, stall_exp;
        logic [31:0] busy_n;
        wr_t         w;
        ga = 1'b0;
        gb = 1'b0;
        if (!RST) begin
            if (REQ_A && REQ_B) begin
                gb = m_pri_b;
                ga = !m_pri_b;
            end else begin
                ga = REQ_A;
                gb = REQ_B;
            end
        end
        stall_exp = ((AR1 != 0) && m_busy[AR1]) || ((AR2 != 0) && m_busy[AR2]);
        #1;
        check("gnt_a", 32'(GNT_A), 32'(ga));
        check("gnt_b", 32'(GNT_B), 32'(gb));
        check("stall", 32'(STALL), 32'(stall_exp));
        if (ga) order = {order, "A"};
        if (gb) order = {order, "B"};
        last_ga = ga;
        last_gb = gb;

        busy_n = m_busy;
        if (cur_we) busy_n[cur_aw] = 1'b0;
        if (RSV && RSV_REG != 0) busy_n[RSV_REG] = 1'b1;
        if (RST) begin
            m_busy = '0;
            m_aw   = '0;
            m_data = '0;
            w.we   = 1'b0;
            m_pri_b = 1'b0;
            m_cnt   = '0;
        end else begin
            m_busy = busy_n;
            w.we   = 1'b0;
            if (ga || gb) begin
                m_aw   = gb ? AW_B : AW_A;
                m_data = gb ? DATA_B : DATA_A;
                w.we   = (m_aw != 0);
            end
            if (gb) begin
                m_pri_b = 1'b0;
                m_cnt   = '0;
            end else if (!REQ_B) begin
                m_cnt = '0;
            end else if (ga) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == LIMIT) m_pri_b = 1'b1;
            end
        end
        w.aw   = m_aw;
        w.data = m_data;
        exp_q.push_back(w);

        @(posedge CLK);
        #1;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("reg_write", 32'(REG_WRITE), 32'(w.we));
            check("aw", 32'(AW), 32'(w.aw));
            check("datain", DATAIN, w.data);
            cur_we = w.we;
            cur_aw = w.aw;
        end
        check("busy", BUSY, m_busy);
    endtask

    initial begin
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; RSV = 1'b1; RSV_REG = 5'd3;
        AW_A = 5'd1; AW_B = 5'd2; DATA_A = 32'h1; DATA_B = 32'h2; AR1 = 5'd0; AR2 = 5'd0;
        @(posedge CLK);
        #1;

        // Reset held with all requests asserted
        step();
        step();
        RST = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; RSV = 1'b0;
        step();

        // Lone A write
        REQ_A = 1'b1; AW_A = 5'd5; DATA_A = 32'hDEADBEEF;
        step();
        check("lone_a_grant", 32'(last_ga), 32'd1);
        REQ_A = 1'b0;
        step();
        check("lone_a_aw", 32'(AW), 32'd5);
        step();

        // Sustained contention: starvation limit forces B periodically
        order = "";
        REQ_A = 1'b1; REQ_B = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_ga) begin AW_A = 5'(10 + i); DATA_A = $urandom; end
            if (last_gb) begin AW_B = 5'(20 + i); DATA_B = $urandom; end
        end
        check("grant_order", 32'(order == "AAABAAAB"), 32'd1);
        REQ_A = 1'b0; REQ_B = 1'b0;
        step();

        // Reserve r7, stall until the bank-write cycle of the write to 7 ends
        RSV = 1'b1; RSV_REG = 5'd7;
        step();
        RSV = 1'b0; AR1 = 5'd7;
        step();
        check("stall_r7", 32'(STALL), 32'd1);
        REQ_B = 1'b1; AW_B = 5'd7; DATA_B = 32'h0000_7777;
        step();
        REQ_B = 1'b0;
        step();
        step();
        check("stall_r7_clear", 32'(STALL), 32'd0);
        AR1 = 5'd0;

        // B write to r0
        REQ_B = 1'b1; AW_B = 5'd0; DATA_B = 32'h1234_5678;
        step();
        REQ_B = 1'b0;
        step();

        // Reserve of r9 coinciding with its bank-write cycle keeps it busy
        RSV = 1'b1; RSV_REG = 5'd9;
        step();
        RSV = 1'b0; REQ_A = 1'b1; AW_A = 5'd9; DATA_A = 32'h9999;
        step();
        REQ_A = 1'b0; RSV = 1'b1;
        step();
        RSV = 1'b0;
        check("busy9_kept", 32'(BUSY[9]), 32'd1);
        step();

        // Randomised traffic with hold-until-granted requesters and occasional reset
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 49) == 0);
            if (!REQ_A || last_ga) begin
                REQ_A = $urandom_range(0, 2) != 0; AW_A = 5'($urandom); DATA_A = $urandom;
            end
            if (!REQ_B || last_gb) begin
                REQ_B = $urandom_range(0, 2) != 0; AW_B = 5'($urandom); DATA_B = $urandom;
            end
            RSV = $urandom_range(0, 1) != 0; RSV_REG = 5'($urandom);
            AR1 = 5'($urandom_range(0, 15)); AR2 = 5'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_write_arbiter.md
BANK_WRITE_ARBITER -- requirements
Module: bank_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, maximum consecutive contended grants to A before B is forced; legal range 1..15.
REQ-002 Port: CLK  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: REQ_A  input  1  write request from requester A (ALU writeback).
REQ-005 Port: AW_A  input  5  destination register of A.
REQ-006 Port: DATA_A  input  32  write data of A.
REQ-007 Port: GNT_A  output  1  grant to A; transfer completes on an edge where REQ_A and GNT_A are both 1.
REQ-008 Port: REQ_B, AW_B, DATA_B, GNT_B  same widths and meanings as REQ-004..007, for requester B (load writeback).
REQ-009 Port: RSV  input  1  reserve a destination register in the scoreboard.
REQ-010 Port: RSV_REG  input  5  register being reserved.
REQ-011 Port: AR1, AR2  input  5 each  read addresses currently presented to the register bank.
REQ-012 Port: STALL  output  1  a read operand is still pending a write.
REQ-013 Port: REG_WRITE  output  1  write enable to the register bank.
REQ-014 Port: AW  output  5  write address to the register bank.
REQ-015 Port: DATAIN  output  32  write data to the register bank.
REQ-016 Port: BUSY  output  32  scoreboard vector; bit r = register r has a write outstanding.

Function
REQ-017 Requesters hold REQ/AW/DATA stable until granted; GNT_A/GNT_B are combinational from REQ and arbiter state; at most one is 1 per cycle.
REQ-018 Arbiter FSM has two states, PRI_A and PRI_B, plus a 4-bit starvation counter CNT.
REQ-019 Only one requester active: it is granted in either state.
REQ-020 Contention in PRI_A: A granted; CNT increments; when the incremented CNT equals STARVE_LIMIT, the next state is PRI_B.
REQ-021 Contention in PRI_B: B granted.
REQ-022 Any B grant: next state PRI_A, CNT cleared. Any cycle with REQ_B=0: CNT cleared. PRI_B persists until B is granted.
REQ-023 A grant on edge E sets REG_WRITE=1, AW, and DATAIN from the granted requester for exactly the one cycle after E.
REQ-024 A cycle following an edge with no grant has REG_WRITE=0; AW and DATAIN hold their last values.
REQ-025 A granted transfer to register 0 completes the handshake but leaves REG_WRITE=0 and does not touch BUSY.
REQ-026 RSV=1 with RSV_REG≠0 sets BUSY[RSV_REG] at the edge. RSV to an already-busy register leaves it busy; no reservation counting.
REQ-027 BUSY[r] clears at the edge that ends the REG_WRITE cycle for register r, so STALL covers the bank-write cycle.
REQ-028 Set and clear of the same bit on the same edge: set wins.
REQ-029 STALL = (AR1≠0 and BUSY[AR1]) or (AR2≠0 and BUSY[AR2]); combinational.
REQ-030 Ungranted requests receive no response; no timeout.

Reset
REQ-031 While RST=1: GNT_A=GNT_B=0; next-cycle outputs REG_WRITE=0, AW=0, DATAIN=0, BUSY=0; state PRI_A; CNT=0.
REQ-032 RST during operation discards any write staged for the next cycle (REG_WRITE=0) and any pending BUSY clear.
REQ-033 First grant is possible in the first cycle with RST=0.

Verification
REQ-034 RST=1 for 2 cycles with REQ_A=REQ_B=RSV=1 -> GNT_A=GNT_B=0, REG_WRITE=0, BUSY=0 throughout and one cycle after.
REQ-035 REQ_A alone, AW_A=5, DATA_A=0xDEADBEEF -> GNT_A=1 same cycle; next cycle REG_WRITE=1, AW=5, DATAIN=0xDEADBEEF; following cycle REG_WRITE=0.
REQ-036 STARVE_LIMIT=3, REQ_A and REQ_B held for 8 grants -> grant order A,A,A,B,A,A,A,B.
REQ-037 RSV with RSV_REG=7, then AR1=7 -> STALL=1 until the edge ending the REG_WRITE cycle of the write to 7, then 0. AR1=AR2=0 -> STALL=0 always.
REQ-038 REQ_B alone, AW_B=0 -> GNT_B=1, REG_WRITE stays 0, BUSY unchanged.
REQ-039 BUSY[9]=1 with the write to 9 in its REG_WRITE cycle, plus RSV=1, RSV_REG=9 on that edge -> BUSY[9] remains 1.
